// File: rtl/pixel_stream_writer.sv
// pixel_stream_writer
//   Takes the RGBA pixel stream coming from the scene stage. Each pixel is tagged with its
//   raster position: sof marks pixel (0,0) and eol marks the last pixel of a line. The tagged
//   pixel goes into a small show-ahead FIFO, which is presented as a valid/ready stream to the
//   display/framebuffer sink.
//   The raster counters are exported so the camera can generate the ray for the next pixel.
//   Backpressure reaches the scene through pixel_ready.
//
// Ports
//   pixel_clk    in   sole clock, rising edge
//   reset        in   asynchronous, active-high; discards all buffered pixels
//   pixel_data   in   [31:0] RGBA from scene, {R,G,B,A} MSB first
//   pixel_valid  in   pixel_data valid this cycle
//   pixel_ready  out  block accepts a pixel this cycle (FIFO not full)
//   pixel_x      out  [$clog2(WIDTH)-1:0]  x of the next pixel to be accepted
//   pixel_y      out  [$clog2(HEIGHT)-1:0] y of the next pixel to be accepted
//   m_data       out  [31:0] buffered pixel, RGBA unchanged (0 when m_valid=0)
//   m_sof        out  m_data is pixel (0,0)
//   m_eol        out  m_data is the last pixel of its line
//   m_valid      out  m_data/m_sof/m_eol valid
//   m_ready      in   sink accepts this cycle
//   frame_done   out  one-cycle pulse, the cycle after the last pixel of a frame is accepted
//   frame_count  out  [15:0] completed frames, wraps 0xFFFF -> 0
//
// Handshake (both sides): a transfer happens on a rising edge where valid && ready are both 1.
//   valid never depends on ready. Data is held stable while valid && !ready.
//   Input side: pixel_ready = !full. A pop in the same cycle does not free room for a push.
//   Output side: m_valid = !empty. The head entry holds still until it is popped.
module pixel_stream_writer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      pixel_clk,
  input  logic                      reset,
  input  logic [31:0]               pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic [$clog2(WIDTH)-1:0]  pixel_x,
  output logic [$clog2(HEIGHT)-1:0] pixel_y,
  output logic [31:0]               m_data,
  output logic                      m_sof,
  output logic                      m_eol,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      frame_done,
  output logic [15:0]               frame_count
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Entry layout: {sof, eol, rgba}
  logic [33:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        x_last;
  logic        y_last;
  logic        sof_tag;
  logic        eol_tag;
  logic [33:0] head;

  // The extra pointer MSB separates "full" (MSBs differ) from "empty" (MSBs equal)
  // when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pixel_ready = !full;
  assign push        = pixel_valid && !full;
  assign m_valid     = !empty;
  assign pop         = m_valid && m_ready;

  assign x_last  = (pixel_x == XW'(WIDTH - 1));
  assign y_last  = (pixel_y == YW'(HEIGHT - 1));
  assign sof_tag = (pixel_x == '0) && (pixel_y == '0);
  assign eol_tag = x_last;

  // Storage is deliberately left unreset. Reset empties the FIFO by clearing the pointers,
  // so stale contents are never presented.
  always_ff @(posedge pixel_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {sof_tag, eol_tag, pixel_data};
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // The raster counters describe the next pixel to be accepted, so they move only on a push.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (push) begin
      if (x_last) begin
        pixel_x <= '0;
        pixel_y <= y_last ? '0 : pixel_y + 1'b1;
      end else begin
        pixel_x <= pixel_x + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= push && x_last && y_last;
      if (push && x_last && y_last) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Show-ahead read: the head entry drives the outputs directly.
  // Outputs are zeroed while nothing is buffered.
  assign head   = mem[rd_ptr[AW-1:0]];
  assign m_data = m_valid ? head[31:0] : 32'd0;
  assign m_sof  = m_valid ? head[33]   : 1'b0;
  assign m_eol  = m_valid ? head[32]   : 1'b0;

endmodule
